// File: rtl/cpu_run_ctrl.sv
// rtl/cpu_run_ctrl.sv - run/debug sequencer for the single-cycle core (optional watchdog: CYCLE_LIMIT_EN)
module cpu_run_ctrl #(
  parameter int IMEM_AW    = 9,
  parameter int MAX_CYCLES = 1000000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [2:0]         cmd_op,
  input  logic [31:0]        cmd_data,
  input  logic               ld_valid,
  output logic               ld_ready,
  input  logic [31:0]        ld_data,
  output logic               imem_we,
  output logic [IMEM_AW-1:0] imem_waddr,
  output logic [31:0]        imem_wdata,
  input  logic [31:0]        pc,
  output logic               cpu_rst,
  output logic               cpu_en,
  output logic [2:0]         state,
  output logic               bp_hit,
  output logic               timeout,
  output logic [31:0]        cycle_cnt
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_RUN  = 3'd2,
    S_STEP = 3'd3,
    S_HALT = 3'd4
  } state_t;

  localparam logic [2:0] OP_LOAD  = 3'd1;
  localparam logic [2:0] OP_RUN   = 3'd2;
  localparam logic [2:0] OP_HALT  = 3'd3;
  localparam logic [2:0] OP_STEP  = 3'd4;
  localparam logic [2:0] OP_SETBP = 3'd5;
  localparam logic [2:0] OP_CLRBP = 3'd6;

  localparam logic [IMEM_AW:0] DEPTH_W  = {1'b1, {IMEM_AW{1'b0}}};
  localparam logic [31:0]      DEPTH_32 = 32'd1 << IMEM_AW;

  state_t           st;
  logic [IMEM_AW:0] ld_cnt;
  logic [IMEM_AW:0] ld_total;
  logic [IMEM_AW:0] ld_cnt_nxt;
  logic [IMEM_AW:0] load_n;
  logic             bp_valid;
  logic [31:0]      bp_addr;
  logic             bp_skip;
  logic             bp_match;
  logic             limit_hit;
  logic             cmd_fire;
  logic             ld_fire;

`ifdef CYCLE_LIMIT_EN
  logic timeout_r;
  assign limit_hit = (cycle_cnt >= 32'(MAX_CYCLES));
  assign timeout   = timeout_r;
`else
  logic [31:0] unused_max_cycles;
  assign unused_max_cycles = 32'(MAX_CYCLES);
  assign limit_hit = 1'b0;
  assign timeout   = 1'b0;
`endif

  assign state      = st;
  assign cmd_ready  = (st != S_LOAD);
  assign ld_ready   = (st == S_LOAD);
  assign cpu_rst    = (st == S_IDLE) || (st == S_LOAD);
  assign cmd_fire   = cmd_valid && cmd_ready;
  assign ld_fire    = ld_valid && ld_ready;
  assign ld_cnt_nxt = ld_cnt + 1'b1;
  assign load_n     = (cmd_data > DEPTH_32) ? DEPTH_W : cmd_data[IMEM_AW:0];
  // bp_skip lets a resumed RUN execute the instruction it stopped on
  assign bp_match   = bp_valid && (pc == bp_addr) && !bp_skip;

  always_comb begin
    cpu_en = 1'b0;
    case (st)
      S_RUN:   cpu_en = !bp_match && !limit_hit;
      S_STEP:  cpu_en = 1'b1;
      default: cpu_en = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st         <= S_IDLE;
      ld_cnt     <= '0;
      ld_total   <= '0;
      imem_we    <= 1'b0;
      imem_waddr <= '0;
      imem_wdata <= '0;
      bp_valid   <= 1'b0;
      bp_addr    <= '0;
      bp_skip    <= 1'b0;
      bp_hit     <= 1'b0;
      cycle_cnt  <= '0;
`ifdef CYCLE_LIMIT_EN
      timeout_r  <= 1'b0;
`endif
    end else begin
      imem_we <= 1'b0;
      if (cpu_en && (cycle_cnt != 32'hFFFF_FFFF))
        cycle_cnt <= cycle_cnt + 32'd1;

      if (cmd_fire && (cmd_op == OP_SETBP)) begin
        bp_addr  <= cmd_data;
        bp_valid <= 1'b1;
      end
      if (cmd_fire && (cmd_op == OP_CLRBP))
        bp_valid <= 1'b0;

      case (st)
        S_IDLE, S_HALT: begin
          if (cmd_fire) begin
            case (cmd_op)
              OP_LOAD: begin
                if (cmd_data != 32'd0) begin
                  ld_total  <= load_n;
                  ld_cnt    <= '0;
                  cycle_cnt <= '0;
                  bp_hit    <= 1'b0;
`ifdef CYCLE_LIMIT_EN
                  timeout_r <= 1'b0;
`endif
                  st        <= S_LOAD;
                end
              end
              OP_RUN: begin
                if (!limit_hit) begin
                  bp_skip <= (st == S_HALT);
                  st      <= S_RUN;
                end
              end
              OP_STEP: st <= S_STEP;
              default: ;
            endcase
          end
        end
        S_LOAD: begin
          if (ld_fire) begin
            imem_we    <= 1'b1;
            imem_waddr <= ld_cnt[IMEM_AW-1:0];
            imem_wdata <= ld_data;
            ld_cnt     <= ld_cnt_nxt;
            if (ld_cnt_nxt == ld_total)
              st <= S_IDLE;
          end
        end
        S_RUN: begin
          bp_skip <= 1'b0;
          if (limit_hit) begin
            st <= S_HALT;
`ifdef CYCLE_LIMIT_EN
            timeout_r <= 1'b1;
`endif
          end
          if (bp_match) begin
            st     <= S_HALT;
            bp_hit <= 1'b1;
          end
          if (cmd_fire && (cmd_op == OP_HALT))
            st <= S_HALT;
        end
        S_STEP:  st <= S_HALT;
        default: st <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// tb/tb_cpu_run_ctrl.sv - directed self-checking bench for cpu_run_ctrl
module tb_cpu_run_ctrl;

  localparam int AW = 9;

  logic          clk = 1'b0;
  logic          reset;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [2:0]    cmd_op;
  logic [31:0]   cmd_data;
  logic          ld_valid;
  logic          ld_ready;
  logic [31:0]   ld_data;
  logic          imem_we;
  logic [AW-1:0] imem_waddr;
  logic [31:0]   imem_wdata;
  logic [31:0]   pc;
  logic          cpu_rst;
  logic          cpu_en;
  logic [2:0]    state;
  logic          bp_hit;
  logic          timeout;
  logic [31:0]   cycle_cnt;

  int n_cmp = 0;
  int n_err = 0;
  int wr_cnt = 0;
  int w0;
  int acc;
  logic [31:0] last_addr = '0;
  logic [31:0] tb_mem [1 << AW];
  logic [31:0] prog [4] = '{32'h00500093, 32'h00100113, 32'h002081B3, 32'h0000006F};

  cpu_run_ctrl #(.IMEM_AW(AW), .MAX_CYCLES(10)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_data(cmd_data),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_data(ld_data),
    .imem_we(imem_we), .imem_waddr(imem_waddr), .imem_wdata(imem_wdata),
    .pc(pc), .cpu_rst(cpu_rst), .cpu_en(cpu_en), .state(state),
    .bp_hit(bp_hit), .timeout(timeout), .cycle_cnt(cycle_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (imem_we) begin
      tb_mem[imem_waddr] = imem_wdata;
      wr_cnt++;
      last_addr = 32'(imem_waddr);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_cmd(input logic [2:0] op, input logic [31:0] d);
    cmd_op    = op;
    cmd_data  = d;
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    cmd_op    = 3'd0;
  endtask

  initial begin
    reset = 1'b0; cmd_valid = 1'b0; cmd_op = 3'd0; cmd_data = '0;
    ld_valid = 1'b0; ld_data = '0; pc = '0;
    repeat (2) tick();
    check("rst_state", 32'(state), 32'd0);
    check("rst_cpu_rst", 32'(cpu_rst), 32'd1);
    check("rst_cpu_en", 32'(cpu_en), 32'd0);
    check("rst_ld_ready", 32'(ld_ready), 32'd0);
    check("rst_imem_we", 32'(imem_we), 32'd0);
    check("rst_cycle_cnt", cycle_cnt, 32'd0);
    check("rst_flags", {30'd0, bp_hit, timeout}, 32'd0);
    check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    reset = 1'b1;
    tick();

    // reset in the middle of an 8-word load
    do_cmd(3'd1, 32'd8);
    check("ld8_state", 32'(state), 32'd1);
    check("ld8_ready", {30'd0, ld_ready, cmd_ready}, 32'd2);
    w0 = wr_cnt;
    for (int i = 0; i < 3; i++) begin
      ld_valid = 1'b1;
      ld_data  = 32'hA000_0000 + 32'(i);
      tick();
    end
    ld_valid = 1'b0;
    tick();
    check("ld8_writes3", 32'(wr_cnt - w0), 32'd3);
    reset = 1'b0;
    #1;
    check("abort_state", 32'(state), 32'd0);
    check("abort_cpu_rst", 32'(cpu_rst), 32'd1);
    check("abort_ld_ready", 32'(ld_ready), 32'd0);
    check("abort_imem_we", 32'(imem_we), 32'd0);
    ld_valid = 1'b1;
    repeat (2) tick();
    reset = 1'b1;
    tick();
    ld_valid = 1'b0;
    tick();
    check("abort_no_more_wr", 32'(wr_cnt - w0), 32'd3);
    check("abort_mem0", tb_mem[0], 32'hA000_0000);
    check("abort_mem2", tb_mem[2], 32'hA000_0002);
    check("abort_idle", 32'(state), 32'd0);

    // zero-length load is ignored
    do_cmd(3'd1, 32'd0);
    check("ld0_state", 32'(state), 32'd0);
    check("ld0_ready", 32'(ld_ready), 32'd0);

    // oversize load clamps to the memory depth
    do_cmd(3'd1, 32'd1000);
    w0 = wr_cnt;
    acc = 0;
    while (state == 3'd1 && acc < 600) begin
      ld_valid = 1'b1;
      ld_data  = 32'h5000_0000 + 32'(acc);
      tick();
      acc++;
    end
    ld_valid = 1'b0;
    tick();
    check("clamp_accepted", 32'(acc), 32'd512);
    check("clamp_writes", 32'(wr_cnt - w0), 32'd512);
    check("clamp_last_addr", last_addr, 32'd511);
    check("clamp_mem511", tb_mem[511], 32'h5000_01FF);
    check("clamp_state", 32'(state), 32'd0);

    // 4-word program with gaps between words
    do_cmd(3'd1, 32'd4);
    w0 = wr_cnt;
    for (int i = 0; i < 4; i++) begin
      ld_valid = 1'b0;
      repeat (i) tick();
      ld_valid = 1'b1;
      ld_data  = prog[i];
      tick();
    end
    ld_valid = 1'b0;
    check("ld4_state", 32'(state), 32'd0);
    check("ld4_ready_drop", 32'(ld_ready), 32'd0);
    tick();
    check("ld4_writes", 32'(wr_cnt - w0), 32'd4);
    check("ld4_last_addr", last_addr, 32'd3);
    for (int i = 0; i < 4; i++) check($sformatf("ld4_mem%0d", i), tb_mem[i], prog[i]);
    check("ld4_cpu_rst", 32'(cpu_rst), 32'd1);

    // breakpoint at 0x8
    do_cmd(3'd5, 32'h8);
    pc = 32'h0;
    do_cmd(3'd2, 32'd0);
    check("run_state", 32'(state), 32'd2);
    check("run_cpu_rst", 32'(cpu_rst), 32'd0);
    check("run_en_pc0", 32'(cpu_en), 32'd1);
    tick();
    pc = 32'h4;
    #1;
    check("run_en_pc4", 32'(cpu_en), 32'd1);
    tick();
    pc = 32'h8;
    #1;
    check("run_en_pc8", 32'(cpu_en), 32'd0);
    tick();
    check("bp_state", 32'(state), 32'd4);
    check("bp_hit", 32'(bp_hit), 32'd1);
    check("bp_cycle_cnt", cycle_cnt, 32'd2);
    check("halt_rst_en", {30'd0, cpu_rst, cpu_en}, 32'd0);

    // resume executes the breakpointed instruction, then HALT mid-run
    do_cmd(3'd2, 32'd0);
    check("resume_en_pc8", 32'(cpu_en), 32'd1);
    tick();
    pc = 32'hC;
    cmd_op = 3'd3; cmd_data = '0; cmd_valid = 1'b1;
    #1;
    check("haltcmd_en", 32'(cpu_en), 32'd1);
    tick();
    cmd_valid = 1'b0; cmd_op = 3'd0;
    check("haltcmd_state", 32'(state), 32'd4);
    check("haltcmd_en_off", 32'(cpu_en), 32'd0);
    check("haltcmd_cnt", cycle_cnt, 32'd4);

    // single steps, one sitting on the breakpoint address
    for (int i = 0; i < 3; i++) begin
      pc = (i == 1) ? 32'h8 : 32'hC;
      do_cmd(3'd4, 32'd0);
      check($sformatf("step%0d_state", i), 32'(state), 32'd3);
      check($sformatf("step%0d_en", i), {30'd0, cpu_rst, cpu_en}, 32'd1);
      tick();
      check($sformatf("step%0d_halt", i), 32'(state), 32'd4);
      check($sformatf("step%0d_en_off", i), 32'(cpu_en), 32'd0);
    end
    check("step_cnt", cycle_cnt, 32'd7);

    // LOAD from HALT clears the sticky flags and counter
    do_cmd(3'd1, 32'd1);
    check("ld_from_halt", {29'd0, state}, 32'd1);
    ld_valid = 1'b1; ld_data = 32'h13;
    tick();
    ld_valid = 1'b0;
    tick();
    check("reload_bp_hit", 32'(bp_hit), 32'd0);
    check("reload_cnt", cycle_cnt, 32'd0);

    // breakpoint match and HALT command together
    do_cmd(3'd5, 32'h20);
    pc = 32'h20;
    do_cmd(3'd2, 32'd0);
    cmd_op = 3'd3; cmd_valid = 1'b1;
    #1;
    check("sim_en", 32'(cpu_en), 32'd0);
    tick();
    cmd_valid = 1'b0; cmd_op = 3'd0;
    check("sim_state", 32'(state), 32'd4);
    check("sim_bp_hit", 32'(bp_hit), 32'd1);
    check("sim_cnt", cycle_cnt, 32'd0);

    pc = 32'h40;
`ifdef CYCLE_LIMIT_EN
    do_cmd(3'd2, 32'd0);
    acc = 0;
    while (state == 3'd2 && acc < 50) begin
      tick();
      acc++;
    end
    check("wd_state", 32'(state), 32'd4);
    check("wd_cnt", cycle_cnt, 32'd10);
    check("wd_timeout", 32'(timeout), 32'd1);
    do_cmd(3'd2, 32'd0);
    check("wd_run_ignored", 32'(state), 32'd4);
    check("wd_en", 32'(cpu_en), 32'd0);
`else
    do_cmd(3'd2, 32'd0);
    repeat (12) tick();
    check("nowd_state", 32'(state), 32'd2);
    check("nowd_cnt", cycle_cnt, 32'd12);
    check("nowd_timeout", 32'(timeout), 32'd0);
    do_cmd(3'd3, 32'd0);
    check("nowd_halt", 32'(state), 32'd4);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
